round_scheduler: RTL and testbench
==================================

ROUND_SCHEDULER -- requirements
Module: round_scheduler

Interface
REQ-001 Parameter TICK_DIV, default 50000000: Clock cycles per one-second tick.
REQ-002 Parameter ROUND_TIME, default 30: seconds allowed per round, range 1..127.
REQ-003 Parameter NUM_ROUNDS, default 8: rounds per game, range 1..15.
REQ-004 Parameter MAX_STRIKES, default 3: wrong answers that end the game, range 1..7.
REQ-005 Port Clock, input, 1: the only clock; every register is on its rising edge.
REQ-006 Port Reset, input, 1: asynchronous, active-low reset.
REQ-007 Port StartGame, input, 1: one-cycle pulse that requests a new game.
REQ-008 Port EqCorrect, input, 4: per-equation correct flag, indexed by equation number.
REQ-009 Port EqWrong, input, 4: per-equation one-cycle pulse marking a completed wrong attempt.
REQ-010 Port StartEq, output, 4: one-hot start pulse to the selected equation block.
REQ-011 Port EqSel, output, 2: index of the active equation.
REQ-012 Port OngoingTimer, output, 7: free-running seconds count, fed to the equation blocks.
REQ-013 Port RoundLeft, output, 7: seconds remaining in the current round.
REQ-014 Port Score, output, 8: correct answers this game.
REQ-015 Port RoundNum, output, 4: current round number, 1-based.
REQ-016 Port Strikes, output, 3: wrong attempts this game.
REQ-017 Port TimeOut, output, 1: one-cycle pulse when a round expires.
REQ-018 Port GameOver, output, 1: level signal, high in OVER.
REQ-019 Port Busy, output, 1: high in every state except IDLE and OVER.

Function
REQ-020 The FSM SHALL have the states IDLE, ISSUE, WAIT, SCORE, NEXT and OVER.
REQ-021 IDLE SHALL go to ISSUE on StartGame and SHALL clear Score, Strikes and OngoingTimer, set RoundNum=1 and reset the prescaler.
REQ-022 ISSUE SHALL step the LFSR once, set EqSel=lfsr[1:0] after the step, assert StartEq[EqSel] for exactly one cycle, load RoundLeft=ROUND_TIME, and go to WAIT.
REQ-023 The LFSR SHALL be 4 bits with taps x^4+x^3+1, a reset seed of 4'b1001, and SHALL step only in ISSUE.
REQ-024 The prescaler SHALL generate a tick every TICK_DIV cycles while Busy; OngoingTimer SHALL increment on each tick and wrap from 99 to 0.
REQ-025 In WAIT, each tick SHALL decrement RoundLeft; when RoundLeft reaches 0, the block SHALL pulse TimeOut and go to NEXT.
REQ-026 In WAIT, EqCorrect[EqSel]=1 SHALL move the FSM to SCORE; SCORE SHALL increment Score, saturating at 255, and go to NEXT.
REQ-027 In WAIT, EqWrong[EqSel] SHALL increment Strikes; when Strikes reaches MAX_STRIKES the FSM SHALL go to OVER, otherwise it SHALL stay in WAIT so the player can retry.
REQ-028 EqCorrect and EqWrong bits for any non-selected equation SHALL be ignored.
REQ-029 Simultaneous events SHALL resolve with priority: correct, then wrong, then timeout.
REQ-030 NEXT SHALL go to OVER if RoundNum==NUM_ROUNDS; otherwise it SHALL increment RoundNum and go to ISSUE.
REQ-031 OVER SHALL hold all counters and freeze OngoingTimer; StartGame in OVER SHALL behave as in IDLE.
REQ-032 StartGame SHALL be ignored while Busy.

Reset
REQ-033 Reset low SHALL force IDLE, the LFSR to 4'b1001, and every output and counter to 0 (StartEq=0, GameOver=0, Busy=0, RoundNum=0), independent of Clock, including mid-round.
REQ-034 The first ISSUE after reset SHALL select EqSel=2'b10, because the LFSR steps from 1001 to 0010.

Structure
REQ-035 The state encodings, the LFSR seed and the taps SHALL live in the shared package round_pkg.
REQ-036 The prescaler and seconds counters SHALL be a sub-module named sec_ticker.

Verification (TICK_DIV=4, ROUND_TIME=3, NUM_ROUNDS=2, MAX_STRIKES=3)
REQ-037 Reset, then StartGame -> one cycle later StartEq=4'b0100, EqSel=2, RoundLeft=3, Busy=1.
REQ-038 No answer for 12 cycles -> TimeOut pulses once, RoundNum=2, new StartEq pulse, Score=0.
REQ-039 EqCorrect[EqSel]=1 in both rounds -> Score=2 and GameOver=1 after round 2; OngoingTimer then frozen.
REQ-040 Three EqWrong[EqSel] pulses in round 1 -> Strikes=3, GameOver=1, RoundNum=1; EqWrong on a non-selected bit leaves Strikes unchanged.
REQ-041 EqCorrect[EqSel] in the same cycle as the final tick -> Score increments and no TimeOut pulse.
REQ-042 Reset low mid-WAIT -> all outputs 0 immediately; after release, the next StartGame again selects EqSel=2.

Source files
------------

// File: rtl/round_pkg.sv
// Shared encodings and LFSR definition for the round scheduler.
package round_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_SCORE,
    ST_NEXT,
    ST_OVER
  } state_t;

  localparam logic [3:0] LFSR_SEED = 4'b1001;
  // x^4+x^3+1: feedback from bits 3 and 0 into the bottom of a left shift
  localparam logic [3:0] LFSR_TAPS = 4'b1001;
  localparam logic [6:0] SEC_WRAP  = 7'd99;

  function automatic logic [3:0] lfsr_step(input logic [3:0] s);
    return {s[2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/sec_ticker.sv
// One-second prescaler plus the free-running 0..99 seconds counter.
module sec_ticker
  import round_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       Enable,
  output logic       Tick,
  output logic [6:0] Seconds
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  assign Tick = Enable && (count == CW'(TICK_DIV - 1));

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count   <= '0;
      Seconds <= '0;
    end else if (Clear) begin
      count   <= '0;
      Seconds <= '0;
    end else if (Enable) begin
      if (Tick) begin
        count   <= '0;
        Seconds <= (Seconds == SEC_WRAP) ? '0 : Seconds + 7'd1;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/round_scheduler.sv
// Game round scheduler: picks an equation per round, times it, and tallies
// score and strikes until the rounds run out or the strike limit is hit.
module round_scheduler
  import round_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned ROUND_TIME  = 30,
  parameter int unsigned NUM_ROUNDS  = 8,
  parameter int unsigned MAX_STRIKES = 3
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       StartGame,
  input  logic [3:0] EqCorrect,
  input  logic [3:0] EqWrong,
  output logic [3:0] StartEq,
  output logic [1:0] EqSel,
  output logic [6:0] OngoingTimer,
  output logic [6:0] RoundLeft,
  output logic [7:0] Score,
  output logic [3:0] RoundNum,
  output logic [2:0] Strikes,
  output logic       TimeOut,
  output logic       GameOver,
  output logic       Busy
);

  state_t     state;
  logic [3:0] lfsr;
  logic [3:0] lfsr_nxt;
  logic       tick;
  logic       start_game;
  logic       sel_correct;
  logic       sel_wrong;
  logic       last_strike;

  assign lfsr_nxt    = lfsr_step(lfsr);
  assign start_game  = StartGame && ((state == ST_IDLE) || (state == ST_OVER));
  assign sel_correct = EqCorrect[EqSel];
  assign sel_wrong   = EqWrong[EqSel];
  assign last_strike = (Strikes == 3'(MAX_STRIKES - 1));

  sec_ticker #(.TICK_DIV(TICK_DIV)) u_sec_ticker (
    .Clock   (Clock),
    .Reset   (Reset),
    .Clear   (start_game),
    .Enable  (Busy),
    .Tick    (tick),
    .Seconds (OngoingTimer)
  );

  // Issue outputs are loaded on the edge entering ISSUE so the StartEq pulse
  // coincides with the ISSUE cycle itself.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      lfsr      <= LFSR_SEED;
      StartEq   <= '0;
      EqSel     <= '0;
      RoundLeft <= '0;
      Score     <= '0;
      RoundNum  <= '0;
      Strikes   <= '0;
      TimeOut   <= 1'b0;
      GameOver  <= 1'b0;
      Busy      <= 1'b0;
    end else begin
      StartEq <= '0;
      TimeOut <= 1'b0;
      case (state)
        ST_IDLE, ST_OVER: begin
          if (StartGame) begin
            Score     <= '0;
            Strikes   <= '0;
            RoundNum  <= 4'd1;
            GameOver  <= 1'b0;
            Busy      <= 1'b1;
            lfsr      <= lfsr_nxt;
            EqSel     <= lfsr_nxt[1:0];
            StartEq   <= 4'b0001 << lfsr_nxt[1:0];
            RoundLeft <= 7'(ROUND_TIME);
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (tick) RoundLeft <= RoundLeft - 7'd1;
          if (!sel_correct && sel_wrong) Strikes <= Strikes + 3'd1;
          // A non-final wrong answer does not block an expiring round.
          if (sel_correct) begin
            state <= ST_SCORE;
          end else if (sel_wrong && last_strike) begin
            GameOver <= 1'b1;
            Busy     <= 1'b0;
            state    <= ST_OVER;
          end else if (tick && (RoundLeft == 7'd1)) begin
            TimeOut <= 1'b1;
            state   <= ST_NEXT;
          end
        end
        ST_SCORE: begin
          if (Score != 8'hFF) Score <= Score + 8'd1;
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          if (RoundNum == 4'(NUM_ROUNDS)) begin
            GameOver <= 1'b1;
            Busy     <= 1'b0;
            state    <= ST_OVER;
          end else begin
            RoundNum  <= RoundNum + 4'd1;
            lfsr      <= lfsr_nxt;
            EqSel     <= lfsr_nxt[1:0];
            StartEq   <= 4'b0001 << lfsr_nxt[1:0];
            RoundLeft <= 7'(ROUND_TIME);
            state     <= ST_ISSUE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_scheduler.sv
// Scoreboard bench: expected issue/timeout/game-over events are queued by the
// stimulus thread and matched by a monitor as the DUT presents them.
module tb_round_scheduler;

  typedef enum int {EV_ISSUE, EV_TIMEOUT, EV_OVER} ev_t;

  typedef struct {
    ev_t        kind;
    logic [3:0] start_eq;
    logic [1:0] sel;
    logic [6:0] left;
    logic [3:0] rnd;
    logic [7:0] score;
    logic [2:0] strikes;
    logic [6:0] ongoing;
    logic       busy;
  } exp_t;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       StartGame = 1'b0;
  logic [3:0] EqCorrect = '0;
  logic [3:0] EqWrong = '0;
  logic [3:0] StartEq;
  logic [1:0] EqSel;
  logic [6:0] OngoingTimer;
  logic [6:0] RoundLeft;
  logic [7:0] Score;
  logic [3:0] RoundNum;
  logic [2:0] Strikes;
  logic       TimeOut;
  logic       GameOver;
  logic       Busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  exp_t        exp_q[$];
  logic        go_q = 1'b0;

  round_scheduler #(
    .TICK_DIV    (4),
    .ROUND_TIME  (3),
    .NUM_ROUNDS  (2),
    .MAX_STRIKES (3)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .StartGame    (StartGame),
    .EqCorrect    (EqCorrect),
    .EqWrong      (EqWrong),
    .StartEq      (StartEq),
    .EqSel        (EqSel),
    .OngoingTimer (OngoingTimer),
    .RoundLeft    (RoundLeft),
    .Score        (Score),
    .RoundNum     (RoundNum),
    .Strikes      (Strikes),
    .TimeOut      (TimeOut),
    .GameOver     (GameOver),
    .Busy         (Busy)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect_ev(input ev_t k, input logic [3:0] se, input logic [1:0] sel,
                                    input logic [6:0] left, input logic [3:0] rnd,
                                    input logic [7:0] sc, input logic [2:0] st,
                                    input logic [6:0] og, input logic busy);
    exp_t e;
    e.kind = k; e.start_eq = se; e.sel = sel; e.left = left; e.rnd = rnd;
    e.score = sc; e.strikes = st; e.ongoing = og; e.busy = busy;
    exp_q.push_back(e);
  endfunction

  task automatic check_event(input ev_t k);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d at %0t, expected none", k, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || StartEq !== e.start_eq || EqSel !== e.sel || RoundLeft !== e.left ||
          RoundNum !== e.rnd || Score !== e.score || Strikes !== e.strikes ||
          OngoingTimer !== e.ongoing || Busy !== e.busy) begin
        miscompares++;
        $display("FAIL event@%0t: got kind=%0d se=%b sel=%0d left=%0d rnd=%0d sc=%0d st=%0d og=%0d busy=%b expected kind=%0d se=%b sel=%0d left=%0d rnd=%0d sc=%0d st=%0d og=%0d busy=%b",
                 $time, k, StartEq, EqSel, RoundLeft, RoundNum, Score, Strikes, OngoingTimer, Busy,
                 e.kind, e.start_eq, e.sel, e.left, e.rnd, e.score, e.strikes, e.ongoing, e.busy);
      end
    end
  endtask

  always @(negedge Clock) begin
    if (Reset) begin
      if (StartEq != 4'b0000) check_event(EV_ISSUE);
      if (TimeOut) check_event(EV_TIMEOUT);
      if (GameOver && !go_q) check_event(EV_OVER);
      go_q = GameOver;
    end else begin
      go_q = 1'b0;
    end
  end

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) @(negedge Clock);
  endtask

  task automatic start_game();
    StartGame = 1'b1;
    @(negedge Clock);
    StartGame = 1'b0;
  endtask

  task automatic pulse_correct(input logic [3:0] v);
    EqCorrect = v;
    @(negedge Clock);
    EqCorrect = '0;
  endtask

  task automatic pulse_wrong(input logic [3:0] v);
    EqWrong = v;
    @(negedge Clock);
    EqWrong = '0;
  endtask

  function automatic logic [63:0] all_outputs();
    return {26'd0, StartEq, EqSel, OngoingTimer, RoundLeft, Score, RoundNum, Strikes,
            TimeOut, GameOver, Busy};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("reset_outputs", all_outputs(), 64'd0);
    @(negedge Clock);
    Reset = 1'b1;
    idle(2);

    // Game 1: both rounds time out
    expect_ev(EV_ISSUE,   4'b0100, 2'd2, 7'd3, 4'd1, 8'd0, 3'd0, 7'd0, 1'b1);
    expect_ev(EV_TIMEOUT, 4'b0000, 2'd2, 7'd0, 4'd1, 8'd0, 3'd0, 7'd3, 1'b1);
    expect_ev(EV_ISSUE,   4'b0001, 2'd0, 7'd3, 4'd2, 8'd0, 3'd0, 7'd3, 1'b1);
    expect_ev(EV_TIMEOUT, 4'b0000, 2'd0, 7'd0, 4'd2, 8'd0, 3'd0, 7'd6, 1'b1);
    expect_ev(EV_OVER,    4'b0000, 2'd0, 7'd0, 4'd2, 8'd0, 3'd0, 7'd6, 1'b0);
    start_game();
    StartGame = 1'b1;  // ignored while busy
    @(negedge Clock);
    StartGame = 1'b0;
    idle(29);

    // Game 2, restarted from OVER: correct answer in both rounds
    expect_ev(EV_ISSUE, 4'b0001, 2'd0, 7'd3, 4'd1, 8'd0, 3'd0, 7'd0, 1'b1);
    expect_ev(EV_ISSUE, 4'b0010, 2'd1, 7'd3, 4'd2, 8'd1, 3'd0, 7'd1, 1'b1);
    expect_ev(EV_OVER,  4'b0000, 2'd1, 7'd3, 4'd2, 8'd2, 3'd0, 7'd2, 1'b0);
    start_game();
    idle(1);
    pulse_correct(4'b0001);
    idle(3);
    pulse_correct(4'b0010);
    idle(12);
    check("timer_frozen_in_over", {57'd0, OngoingTimer}, 64'd2);
    check("gameover_level", {63'd0, GameOver}, 64'd1);

    // Game 3: correct lands on the final tick, then reset mid-WAIT
    expect_ev(EV_ISSUE, 4'b1000, 2'd3, 7'd3, 4'd1, 8'd0, 3'd0, 7'd0, 1'b1);
    expect_ev(EV_ISSUE, 4'b1000, 2'd3, 7'd3, 4'd2, 8'd1, 3'd0, 7'd3, 1'b1);
    start_game();
    idle(11);
    pulse_correct(4'b1000);
    check("no_timeout_on_final_tick", {63'd0, TimeOut}, 64'd0);
    idle(3);
    #2 Reset = 1'b0;
    #1 check("async_reset_mid_wait", all_outputs(), 64'd0);
    idle(2);
    Reset = 1'b1;
    idle(1);

    // Game 4: strikes end the game; non-selected wrong is ignored
    expect_ev(EV_ISSUE, 4'b0100, 2'd2, 7'd3, 4'd1, 8'd0, 3'd0, 7'd0, 1'b1);
    expect_ev(EV_OVER,  4'b0000, 2'd2, 7'd2, 4'd1, 8'd0, 3'd3, 7'd1, 1'b0);
    start_game();
    idle(1);
    pulse_wrong(4'b0001);
    check("strikes_nonselected", {61'd0, Strikes}, 64'd0);
    pulse_wrong(4'b0100);
    check("strikes_first", {61'd0, Strikes}, 64'd1);
    pulse_wrong(4'b0100);
    check("strikes_second", {61'd0, Strikes}, 64'd2);
    pulse_wrong(4'b0100);
    idle(3);
    check("strikes_final_roundnum", {57'd0, Strikes, RoundNum}, {57'd0, 3'd3, 4'd1});

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events: got %0d outstanding expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
